// File: rtl/step_ramp_gen_pkg.sv
// Shared motion-control definitions: FSM states and the default divisor limits
// common to the ramp generator and the free-running divider path.
package motor_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEL  = 3'd1,
        CRUISE = 3'd2,
        DECEL  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int          DEF_STEPS_W   = 16;
    localparam logic [31:0] DEF_DIV_START = 32'd800;
    localparam logic [31:0] DEF_DIV_MIN   = 32'd100;
    localparam logic [31:0] DEF_DIV_STEP  = 32'd100;

endpackage

// File: rtl/step_ramp_gen_if.sv
// Command / status bundle between a motion master and the step ramp generator.
interface step_ramp_gen_if #(
    parameter int STEPS_W = 16
);
    logic               start;
    logic [STEPS_W-1:0] target_steps;
    logic               dir_in;
    logic               abort;
    logic               step_pulse;
    logic               cw_out;
    logic               busy;
    logic               done;
    logic [STEPS_W-1:0] steps_done;
    logic [31:0]        cur_div;

    modport master (
        output start, target_steps, dir_in, abort,
        input  step_pulse, cw_out, busy, done, steps_done, cur_div
    );

    modport slave (
        input  start, target_steps, dir_in, abort,
        output step_pulse, cw_out, busy, done, steps_done, cur_div
    );
endinterface

// File: rtl/step_ramp_gen_timer.sv
// Period timer: counts 0..i_div and flags the terminal count; also used by the
// free-running divider path.
module step_period_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic [31:0] i_div,
    output logic        o_tick
);
    logic [31:0] r_cnt;

    assign o_tick = (r_cnt == i_div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
        end
    end
endmodule

// File: rtl/step_ramp_gen.sv
// Trapezoidal step generator: accelerates from DIV_START to DIV_MIN, cruises,
// then decelerates symmetrically so the motor always stops at low speed.
module step_ramp_gen
    import motor_pkg::*;
#(
    parameter int          STEPS_W   = DEF_STEPS_W,
    parameter logic [31:0] DIV_START = DEF_DIV_START,
    parameter logic [31:0] DIV_MIN   = DEF_DIV_MIN,
    parameter logic [31:0] DIV_STEP  = DEF_DIV_STEP
) (
    input  logic           clk,
    input  logic           xres,
    step_ramp_gen_if.slave bus
);
    state_t             r_state, w_nxt_state;
    logic [STEPS_W-1:0] r_target, w_nxt_target;
    logic [STEPS_W-1:0] r_steps_done, w_nxt_steps;
    logic [STEPS_W-1:0] r_ramp_cnt, w_nxt_ramp;
    logic [31:0]        r_cur_div, w_nxt_div;
    logic               r_cw, w_nxt_cw;
    logic [STEPS_W:0]   w_lim;
    logic [STEPS_W-1:0] w_sd_inc, w_rem;
    logic               w_dn_ok, w_busy, w_done, w_tick, w_step;

    // Slowing down saturates at the start divisor; 33-bit sum avoids wrap.
    function automatic logic [31:0] f_div_up(input logic [31:0] cur);
        logic [32:0] sum;
        sum = {1'b0, cur} + {1'b0, DIV_STEP};
        return (sum > {1'b0, DIV_START}) ? DIV_START : sum[31:0];
    endfunction

    step_period_timer u_timer (
        .clk    (clk),
        .rst_n  (xres),
        .i_clr  (!w_busy),
        .i_div  (r_cur_div),
        .o_tick (w_tick)
    );

    assign w_sd_inc = r_steps_done + STEPS_W'(1);
    assign w_rem    = r_target - w_sd_inc;
    assign w_dn_ok  = (r_cur_div > DIV_STEP) && ((r_cur_div - DIV_STEP) > DIV_MIN);

    always_ff @(posedge clk or negedge xres) begin
        if (!xres) r_state <= IDLE;
        else       r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_target = r_target;
        w_nxt_steps  = r_steps_done;
        w_nxt_ramp   = r_ramp_cnt;
        w_nxt_div    = r_cur_div;
        w_nxt_cw     = r_cw;
        w_lim        = '0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_nxt_target = bus.target_steps;
                    w_nxt_cw     = bus.dir_in;
                    w_nxt_steps  = '0;
                    w_nxt_ramp   = '0;
                    w_nxt_div    = DIV_START;
                    w_nxt_state  = (bus.target_steps == '0) ? DONE : ACCEL;
                end
            end
            ACCEL, CRUISE, DECEL: begin
                if (w_step) begin
                    w_nxt_steps = w_sd_inc;
                    if (w_rem == '0) begin
                        w_nxt_state = DONE;
                    end else if (r_state != DECEL && w_rem <= r_ramp_cnt) begin
                        w_nxt_state = DECEL;
                        w_nxt_div   = f_div_up(r_cur_div);
                        w_nxt_ramp  = r_ramp_cnt - STEPS_W'(1);
                    end else if (r_state == ACCEL && !w_dn_ok) begin
                        w_nxt_state = CRUISE;
                        w_nxt_div   = DIV_MIN;
                        w_nxt_ramp  = r_ramp_cnt + STEPS_W'(1);
                    end else if (r_state == ACCEL) begin
                        w_nxt_div   = r_cur_div - DIV_STEP;
                        w_nxt_ramp  = r_ramp_cnt + STEPS_W'(1);
                    end else if (r_state == DECEL) begin
                        w_nxt_div   = f_div_up(r_cur_div);
                        if (r_ramp_cnt != '0) w_nxt_ramp = r_ramp_cnt - STEPS_W'(1);
                    end
                end
                // Abort shortens the move to what the ramp-down needs, seen after the boundary.
                if (bus.abort && r_state != DECEL) begin
                    w_lim = {1'b0, w_nxt_steps} + {1'b0, w_nxt_ramp};
                    if (w_lim < {1'b0, w_nxt_target}) w_nxt_target = w_lim[STEPS_W-1:0];
                    if (w_nxt_target == w_nxt_steps) w_nxt_state = DONE;
                end
            end
            DONE:    w_nxt_state = IDLE;
            default: w_nxt_state = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == ACCEL) || (r_state == CRUISE) || (r_state == DECEL);
        w_done = (r_state == DONE);
        w_step = w_busy && w_tick;
    end

    always_ff @(posedge clk or negedge xres) begin
        if (!xres) begin
            r_target     <= '0;
            r_steps_done <= '0;
            r_ramp_cnt   <= '0;
            r_cur_div    <= DIV_START;
            r_cw         <= 1'b1;
        end else begin
            r_target     <= w_nxt_target;
            r_steps_done <= w_nxt_steps;
            r_ramp_cnt   <= w_nxt_ramp;
            r_cur_div    <= w_nxt_div;
            r_cw         <= w_nxt_cw;
        end
    end

    assign bus.step_pulse = w_step;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.cw_out     = r_cw;
    assign bus.steps_done = r_steps_done;
    assign bus.cur_div    = r_cur_div;
endmodule

// File: tb/tb_step_ramp_gen.sv
// Bench for step_ramp_gen: directed vector table, hand sequences for start-while-busy
// and mid-move reset, and random moves checked against a step-level profile model.
module tb_step_ramp_gen;
    import motor_pkg::*;

    localparam int SW    = 16;
    localparam int LIMIT = 12000;
    localparam int DS    = 800;
    localparam int DM    = 100;
    localparam int DSTEP = 100;

    logic clk = 1'b0;
    logic xres;
    always #10 clk = ~clk;

    step_ramp_gen_if #(.STEPS_W(SW)) bus ();

    step_ramp_gen #(.STEPS_W(SW)) dut (
        .clk  (clk),
        .xres (xres),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Expected profile: pulse cycles (relative to acceptance) and the done cycle.
    int m_pulses[$];
    int m_done;

    task automatic model_move(input int T, input int A);
        int  t, sd, ramp, div, tgt, pc, rem;
        bit  decel, cruise, ab_used, was_active;
        m_pulses.delete();
        tgt = T; sd = 0; ramp = 0; div = DS; t = 0;
        decel = 0; cruise = 0; ab_used = (A == 0);
        if (T == 0) begin
            m_done = 1;
            return;
        end
        forever begin
            pc = t + div + 1;
            if (!ab_used && !decel && A < pc) begin
                ab_used = 1;
                if (sd + ramp < tgt) tgt = sd + ramp;
                if (tgt == sd) begin
                    m_done = A + 1;
                    return;
                end
            end
            m_pulses.push_back(pc);
            sd++;
            rem = tgt - sd;
            was_active = !decel;
            if (rem == 0) begin
                m_done = pc + 1;
                return;
            end else if (!decel && rem <= ramp) begin
                decel = 1;
                div   = (div + DSTEP > DS) ? DS : div + DSTEP;
                ramp--;
            end else if (!decel && !cruise) begin
                if (div - DSTEP <= DM) begin
                    div    = DM;
                    cruise = 1;
                end else begin
                    div = div - DSTEP;
                end
                ramp++;
            end else if (decel) begin
                div = (div + DSTEP > DS) ? DS : div + DSTEP;
                if (ramp > 0) ramp--;
            end
            if (!ab_used && was_active && A == pc) begin
                ab_used = 1;
                if (sd + ramp < tgt) tgt = sd + ramp;
                if (tgt == sd) begin
                    m_done = pc + 1;
                    return;
                end
            end
            t = pc;
        end
    endtask

    // Runs one move; R > 0 re-strobes start (different command) in that cycle.
    task automatic run_move(input int T, input bit d, input int A, input int R, input string nm,
                            output int np, output int lastp, output int dc);
        int got[$];
        int busy_bad, bad, k;
        bit seen;
        model_move(T, A);
        busy_bad = 0; bad = 0; seen = 0; dc = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.target_steps = SW'(T); bus.dir_in = d; bus.abort = 1'b0;
        @(posedge clk);
        for (k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            bus.start = (k == R);
            if (k == R) begin
                bus.target_steps = SW'(T + 9);
                bus.dir_in       = ~d;
            end
            bus.abort = (k == A);
            if (bus.step_pulse) got.push_back(k);
            if (bus.busy != (bus.done ? 1'b0 : 1'b1)) busy_bad++;
            if (bus.done) begin
                seen = 1;
                dc   = k;
                check({nm, " steps_done"}, bus.steps_done, m_pulses.size());
                check({nm, " cw_out"}, bus.cw_out, d);
                break;
            end
        end
        bus.start = 1'b0; bus.abort = 1'b0;
        check({nm, " done_seen"}, seen, 1);
        check({nm, " done_cycle"}, dc, m_done);
        check({nm, " busy_bad_cycles"}, busy_bad, 0);
        check({nm, " pulse_count"}, got.size(), m_pulses.size());
        for (int i = 0; i < got.size() && i < m_pulses.size(); i++)
            if (got[i] != m_pulses[i]) bad++;
        check({nm, " pulse_cycles_bad"}, bad, 0);
        @(negedge clk);
        check({nm, " done_one_cycle"}, bus.done, 0);
        check({nm, " idle_busy"}, bus.busy, 0);
        np = got.size();
        if (np >= 2)      lastp = got[np-1] - got[np-2];
        else if (np == 1) lastp = got[0];
        else              lastp = 0;
    endtask

    typedef struct {
        int target;
        bit dir;
        int abort_cyc;
        int exp_pulses;
        int exp_last;
        int exp_done;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int np, lastp, dc, cnt;
        bus.start = 1'b0; bus.abort = 1'b0; bus.target_steps = '0; bus.dir_in = 1'b0;
        xres = 1'b0;

        vecs[0] = '{4,  1'b0, 0,    4,  701, 2805};
        vecs[1] = '{20, 1'b1, 0,    20, 801, 7621};
        vecs[2] = '{20, 1'b0, 3820, 17, 701, 6618};
        vecs[3] = '{5,  1'b1, 1,    0,  0,   2};
        vecs[4] = '{0,  1'b0, 0,    0,  0,   1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst step_pulse", bus.step_pulse, 0);
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst cw_out", bus.cw_out, 1);
        check("rst steps_done", bus.steps_done, 0);
        check("rst cur_div", bus.cur_div, 800);
        xres = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_move(vecs[v].target, vecs[v].dir, vecs[v].abort_cyc, 0, $sformatf("vec%0d", v),
                     np, lastp, dc);
            check($sformatf("vec%0d table_pulses", v), np, vecs[v].exp_pulses);
            check($sformatf("vec%0d table_last_period", v), lastp, vecs[v].exp_last);
            check($sformatf("vec%0d table_done", v), dc, vecs[v].exp_done);
        end

        run_move(4, 1'b1, 0, 300, "busy_start", np, lastp, dc);
        check("busy_start table_pulses", np, 4);

        @(negedge clk);
        bus.start = 1'b1; bus.target_steps = SW'(20); bus.dir_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3700) @(negedge clk);
        check("cruise busy", bus.busy, 1);
        check("cruise cur_div", bus.cur_div, 100);
        #2 xres = 1'b0;
        #1;
        check("midrst step_pulse", bus.step_pulse, 0);
        check("midrst busy", bus.busy, 0);
        check("midrst done", bus.done, 0);
        check("midrst cur_div", bus.cur_div, 800);
        check("midrst cw_out", bus.cw_out, 1);
        check("midrst steps_done", bus.steps_done, 0);
        cnt = 0;
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if (bus.step_pulse) cnt++;
        end
        check("midrst pulses_in_reset", cnt, 0);
        xres = 1'b1;
        run_move(4, 1'b0, 0, 0, "post_rst", np, lastp, dc);
        check("post_rst table_pulses", np, 4);
        check("post_rst table_last_period", lastp, 701);
        check("post_rst table_done", dc, 2805);

        for (int r = 0; r < 4; r++) begin
            int t, a;
            bit d;
            t = $urandom_range(0, 22);
            d = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6000);
            run_move(t, d, a, 0, $sformatf("rnd%0d_t%0d_a%0d", r, t, a), np, lastp, dc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
